// File: rtl/periph_decode_arb.sv
// Arbitrates IFU/LSU requests onto one shared peripheral address decoder and
// returns a held, fault-checked select vector. Optional: PERIPH_ARB_OVERLAP_CHECK_EN.
module periph_decode_arb #(
  parameter int PA_BITS  = 56,
  parameter int NREGIONS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                IFUReq,
  input  logic [PA_BITS-1:0]  IFUAdr,
  input  logic [1:0]          IFUSize,
  output logic                IFUGnt,
  input  logic                LSUReq,
  input  logic [PA_BITS-1:0]  LSUAdr,
  input  logic [1:0]          LSUSize,
  input  logic                LSUWrite,
  output logic                LSUGnt,
  output logic [PA_BITS-1:0]  DecAdr,
  output logic [1:0]          DecSize,
  output logic                DecWrite,
  input  logic [NREGIONS-1:0] DecSel,
  output logic                RspValid,
  output logic                RspOwner,
  output logic [NREGIONS-1:0] RspSel,
  output logic                RspFault,
  input  logic                RspReady
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DECODE = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0] state;
  logic [1:0] starve_cnt;
  logic       lat_owner;
  logic       lsu_win;
  logic       ifu_win;
  logic       sel_none;
  logic       sel_multi;
  logic       fault_now;

  // LSU normally wins; after two contested LSU wins in a row the IFU gets a turn.
  always_comb begin
    lsu_win = 1'b0;
    ifu_win = 1'b0;
    if (state == IDLE && !reset) begin
      lsu_win = LSUReq && !(IFUReq && (starve_cnt == 2'd2));
      ifu_win = IFUReq && !lsu_win;
    end
  end

  assign IFUGnt   = ifu_win;
  assign LSUGnt   = lsu_win;
  assign RspValid = (state == RESP);

  always_comb begin
    sel_none = (DecSel == '0);
`ifdef PERIPH_ARB_OVERLAP_CHECK_EN
    sel_multi = ((DecSel & (DecSel - NREGIONS'(1))) != '0);
`else
    sel_multi = 1'b0;
`endif
    fault_now = sel_none | sel_multi;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= 2'd0;
      lat_owner  <= 1'b0;
      DecAdr     <= '0;
      DecSize    <= 2'd0;
      DecWrite   <= 1'b0;
      RspOwner   <= 1'b0;
      RspSel     <= '0;
      RspFault   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (lsu_win) begin
            DecAdr    <= LSUAdr;
            DecSize   <= LSUSize;
            DecWrite  <= LSUWrite;
            lat_owner <= 1'b1;
            if (IFUReq && (starve_cnt != 2'd2))
              starve_cnt <= starve_cnt + 2'd1;
            state <= DECODE;
          end else if (ifu_win) begin
            DecAdr     <= IFUAdr;
            DecSize    <= IFUSize;
            DecWrite   <= 1'b0;
            lat_owner  <= 1'b0;
            starve_cnt <= 2'd0;
            state      <= DECODE;
          end
        end
        DECODE: begin
          RspOwner <= lat_owner;
          RspSel   <= fault_now ? '0 : DecSel;
          RspFault <= fault_now;
          state    <= RESP;
        end
        RESP: begin
          if (RspReady)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_decode_arb.sv
// Self-checking bench for periph_decode_arb: directed scenarios plus a
// randomized run checked against a grant-history reference model.
module tb_periph_decode_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        IFUReq, LSUReq, LSUWrite, RspReady;
  logic [55:0] IFUAdr, LSUAdr;
  logic [1:0]  IFUSize, LSUSize;
  logic        IFUGnt, LSUGnt, DecWrite, RspValid, RspOwner, RspFault;
  logic [55:0] DecAdr;
  logic [1:0]  DecSize;
  logic [7:0]  DecSel, RspSel;

  int errors = 0;
  int checks = 0;
  bit overlap_en;

  // Reference model: transaction phase, latched request, held response, grant history
  int          m_phase;
  logic [55:0] m_adr;
  logic [1:0]  m_size;
  logic        m_write, m_owner, m_rsp_owner, m_rsp_fault;
  logic [7:0]  m_rsp_sel;
  int          m_hist[$];  // 0 = IFU grant, 1 = contested LSU grant, 2 = lone LSU grant

  periph_decode_arb dut (
    .clk(clk), .reset(reset),
    .IFUReq(IFUReq), .IFUAdr(IFUAdr), .IFUSize(IFUSize), .IFUGnt(IFUGnt),
    .LSUReq(LSUReq), .LSUAdr(LSUAdr), .LSUSize(LSUSize), .LSUWrite(LSUWrite), .LSUGnt(LSUGnt),
    .DecAdr(DecAdr), .DecSize(DecSize), .DecWrite(DecWrite), .DecSel(DecSel),
    .RspValid(RspValid), .RspOwner(RspOwner), .RspSel(RspSel), .RspFault(RspFault),
    .RspReady(RspReady)
  );

  always #5 clk = ~clk;

  function automatic int lsu_streak();
    int n = 0;
    for (int i = m_hist.size() - 1; i >= 0; i--) begin
      if (m_hist[i] == 0) break;
      if (m_hist[i] == 1) n++;
    end
    return n;
  endfunction

  function automatic bit pred_lsu();
    return (m_phase == 0) && !reset && LSUReq && !(IFUReq && lsu_streak() >= 2);
  endfunction

  function automatic bit pred_ifu();
    return (m_phase == 0) && !reset && IFUReq && !pred_lsu();
  endfunction

  function automatic bit exp_fault(input logic [7:0] s);
    return (s == 8'h00) || (overlap_en && $countones(s) > 1);
  endfunction

  task automatic model_update();
    bit gl, gi;
    gl = pred_lsu();
    gi = pred_ifu();
    if (reset) begin
      m_phase = 0; m_adr = '0; m_size = '0; m_write = 0; m_owner = 0;
      m_rsp_owner = 0; m_rsp_fault = 0; m_rsp_sel = '0;
      m_hist.delete();
    end else if (m_phase == 0) begin
      if (gl) begin
        m_adr = LSUAdr; m_size = LSUSize; m_write = LSUWrite; m_owner = 1;
        m_hist.push_back(IFUReq ? 1 : 2);
        m_phase = 1;
      end else if (gi) begin
        m_adr = IFUAdr; m_size = IFUSize; m_write = 0; m_owner = 0;
        m_hist.push_back(0);
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_rsp_owner = m_owner;
      m_rsp_fault = exp_fault(DecSel);
      m_rsp_sel   = m_rsp_fault ? 8'h00 : DecSel;
      m_phase     = 2;
    end else if (RspReady) begin
      m_phase = 0;
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1; IFUReq = 0; LSUReq = 0;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; IFUReq = 1; LSUReq = 1;
    tick(); tick();
    #1;
    checks++;
    if ({IFUGnt, LSUGnt, RspValid, RspOwner, RspFault, DecWrite} !== 6'b0 ||
        DecAdr !== 56'h0 || DecSize !== 2'd0 || RspSel !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_outputs: gnt=%b%b valid=%b owner=%b fault=%b adr=%h sel=%h, required all zero",
               IFUGnt, LSUGnt, RspValid, RspOwner, RspFault, DecAdr, RspSel);
    end
    IFUReq = 0; LSUReq = 0; reset = 0;
    tick();
  endtask

  task automatic test_single_lsu();
    LSUReq = 1; LSUAdr = 56'h0000_0000_0200_0000; LSUSize = 2; LSUWrite = 0;
    DecSel = 8'h04; RspReady = 1;
    #1;
    checks++;
    if (LSUGnt !== 1'b1 || IFUGnt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_gnt: lsu=%b ifu=%b, required 1 0", LSUGnt, IFUGnt);
    end
    tick(); LSUReq = 0; #1;
    checks++;
    if (DecAdr !== 56'h0000_0000_0200_0000 || DecSize !== 2'd2 || RspValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_decode: adr=%h size=%0d valid=%b, required 2000000 2 0", DecAdr, DecSize, RspValid);
    end
    tick(); #1;
    checks++;
    if (RspValid !== 1'b1 || RspOwner !== 1'b1 || RspSel !== 8'h04 || RspFault !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_resp: valid=%b owner=%b sel=%h fault=%b, required 1 1 04 0",
               RspValid, RspOwner, RspSel, RspFault);
    end
    tick(); #1;
    checks++;
    if (RspValid !== 1'b0 || LSUGnt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_idle: valid=%b gnt=%b, required 0 0", RspValid, LSUGnt);
    end
  endtask

  task automatic test_fairness();
    bit exp_lsu[6] = '{1, 1, 0, 1, 1, 0};
    reset_dut();
    IFUReq = 1; LSUReq = 1; RspReady = 1; DecSel = 8'h01;
    for (int g = 0; g < 6; g++) begin
      bit found = 0;
      bit who = 0;
      int wait_c = 0;
      for (int c = 0; c < 8 && !found; c++) begin
        #1;
        if (IFUGnt || LSUGnt) begin
          found = 1; who = LSUGnt; wait_c = c;
          checks++;
          if (IFUGnt && LSUGnt) begin
            errors++;
            $display("[TB] FAIL fair_both: grant %0d gave both gnts", g);
          end
        end
        tick();
      end
      checks++;
      if (!found || who !== exp_lsu[g]) begin
        errors++;
        $display("[TB] FAIL fair_order: grant %0d found=%b lsu=%b, required lsu=%b", g, found, who, exp_lsu[g]);
      end
      checks++;
      if (g > 0 && wait_c != 2) begin
        errors++;
        $display("[TB] FAIL fair_gap: grant %0d idle cycles=%0d, required 2", g, wait_c);
      end
    end
    IFUReq = 0; LSUReq = 0;
    tick(); tick();
  endtask

  task automatic test_fault_stall();
    logic       o_v, o_own, o_f;
    logic [7:0] o_sel;
    IFUReq = 1; IFUAdr = {24'h0, $urandom}; IFUSize = 1; DecSel = 8'h00; RspReady = 0;
    #1;
    checks++;
    if (IFUGnt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_gnt: ifu=%b, required 1", IFUGnt);
    end
    tick(); IFUReq = 0;
    tick(); IFUReq = 1; LSUReq = 1; #1;
    o_v = RspValid; o_own = RspOwner; o_sel = RspSel; o_f = RspFault;
    checks++;
    if (o_v !== 1'b1 || o_f !== 1'b1 || o_sel !== 8'h00 || o_own !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fault_resp: valid=%b fault=%b sel=%h owner=%b, required 1 1 00 0", o_v, o_f, o_sel, o_own);
    end
    for (int i = 0; i < 5; i++) begin
      DecSel = 8'(1 << $urandom_range(0, 7));
      #1;
      checks++;
      if (RspValid !== o_v || RspOwner !== o_own || RspSel !== o_sel || RspFault !== o_f ||
          IFUGnt !== 1'b0 || LSUGnt !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_hold: cycle %0d valid=%b owner=%b sel=%h fault=%b gnt=%b%b, required %b %b %h %b 00",
                 i, RspValid, RspOwner, RspSel, RspFault, IFUGnt, LSUGnt, o_v, o_own, o_sel, o_f);
      end
      tick();
    end
    RspReady = 1; #1;
    checks++;
    if (IFUGnt !== 1'b0 || LSUGnt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL handshake_nogrant: gnt=%b%b, required 00", IFUGnt, LSUGnt);
    end
    tick(); #1;
    checks++;
    if (RspValid !== 1'b0 || LSUGnt !== 1'b1 || IFUGnt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL after_stall: valid=%b lsu=%b ifu=%b, required 0 1 0", RspValid, LSUGnt, IFUGnt);
    end
    tick(); IFUReq = 0; LSUReq = 0;
    tick(); tick();
  endtask

  task automatic test_overlap();
    LSUReq = 1; LSUAdr = {$urandom, $urandom} >> 8; LSUWrite = 1; DecSel = 8'h05; RspReady = 1;
    tick(); LSUReq = 0;
    tick(); #1;
    checks++;
    if (overlap_en ? (RspFault !== 1'b1 || RspSel !== 8'h00) : (RspFault !== 1'b0 || RspSel !== 8'h05)) begin
      errors++;
      $display("[TB] FAIL overlap: fault=%b sel=%h, required %b %h", RspFault, RspSel, overlap_en, overlap_en ? 8'h00 : 8'h05);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [55:0] ia;
    LSUReq = 1; LSUAdr = 56'hAB_CDEF_0123_4567; LSUSize = 3; LSUWrite = 1; DecSel = 8'h02; RspReady = 1;
    tick();
    ia = 56'h12_3456_789A_BCDE;
    LSUReq = 0; IFUReq = 1; IFUAdr = ia; IFUSize = 0; reset = 1; #1;
    checks++;
    if (DecAdr !== 56'hAB_CDEF_0123_4567 || DecWrite !== 1'b1 || IFUGnt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_decode: adr=%h wr=%b ifu=%b, required abcdef01234567 1 0", DecAdr, DecWrite, IFUGnt);
    end
    tick(); reset = 0; #1;
    checks++;
    if ({RspValid, RspOwner, RspFault, DecWrite, LSUGnt} !== 5'b0 || RspSel !== 8'h00 ||
        DecAdr !== 56'h0 || DecSize !== 2'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset_vals: valid=%b owner=%b fault=%b wr=%b sel=%h adr=%h size=%0d, required zeros",
               RspValid, RspOwner, RspFault, DecWrite, RspSel, DecAdr, DecSize);
    end
    checks++;
    if (IFUGnt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_regrant: ifu=%b, required 1", IFUGnt);
    end
    tick(); IFUReq = 0; #1;
    checks++;
    if (DecAdr !== ia || DecWrite !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_ifu_decode: adr=%h wr=%b, required %h 0", DecAdr, DecWrite, ia);
    end
    tick(); #1;
    checks++;
    if (RspValid !== 1'b1 || RspOwner !== 1'b0 || RspSel !== 8'h02) begin
      errors++;
      $display("[TB] FAIL mid_ifu_resp: valid=%b owner=%b sel=%h, required 1 0 02", RspValid, RspOwner, RspSel);
    end
    tick();
  endtask

  task automatic test_ifu_nowrite();
    LSUReq = 1; LSUWrite = 1; DecSel = 8'h08; RspReady = 1;
    tick(); LSUReq = 0; tick(); tick();
    IFUReq = 1; IFUAdr = 56'h00_0000_0000_1000; IFUSize = 3; LSUWrite = 1;
    tick(); IFUReq = 0; #1;
    checks++;
    if (DecWrite !== 1'b0 || DecSize !== 2'd3 || DecAdr !== 56'h1000) begin
      errors++;
      $display("[TB] FAIL ifu_nowrite: wr=%b size=%0d adr=%h, required 0 3 1000", DecWrite, DecSize, DecAdr);
    end
    tick(); tick();
  endtask

  task automatic test_random();
    reset_dut();
    for (int n = 0; n < 600; n++) begin
      bit gi, gl;
      if (!IFUReq) begin
        IFUReq = ($urandom_range(0, 2) == 0);
        IFUAdr = {$urandom, $urandom} >> 8; IFUSize = 2'($urandom);
      end else if ($urandom_range(0, 19) == 0) IFUReq = 0;
      if (!LSUReq) begin
        LSUReq = ($urandom_range(0, 1) == 0);
        LSUAdr = {$urandom, $urandom} >> 8; LSUSize = 2'($urandom); LSUWrite = 1'($urandom);
      end else if ($urandom_range(0, 19) == 0) LSUReq = 0;
      case ($urandom_range(0, 3))
        0:       DecSel = 8'h00;
        1:       DecSel = 8'($urandom);
        default: DecSel = 8'(1 << $urandom_range(0, 7));
      endcase
      RspReady = ($urandom_range(0, 2) != 0);
      reset = ($urandom_range(0, 79) == 0);
      #1;
      checks++;
      if (IFUGnt !== pred_ifu() || LSUGnt !== pred_lsu()) begin
        errors++;
        $display("[TB] FAIL rnd_gnt: cycle %0d gnt ifu/lsu=%b%b, required %b%b", n, IFUGnt, LSUGnt, pred_ifu(), pred_lsu());
      end
      checks++;
      if (RspValid !== (m_phase == 2) || RspOwner !== m_rsp_owner || RspSel !== m_rsp_sel || RspFault !== m_rsp_fault) begin
        errors++;
        $display("[TB] FAIL rnd_rsp: cycle %0d valid=%b owner=%b sel=%h fault=%b, required %b %b %h %b",
                 n, RspValid, RspOwner, RspSel, RspFault, m_phase == 2, m_rsp_owner, m_rsp_sel, m_rsp_fault);
      end
      checks++;
      if (DecAdr !== m_adr || DecSize !== m_size || DecWrite !== m_write) begin
        errors++;
        $display("[TB] FAIL rnd_dec: cycle %0d adr=%h size=%0d wr=%b, required %h %0d %b",
                 n, DecAdr, DecSize, DecWrite, m_adr, m_size, m_write);
      end
      gi = pred_ifu();
      gl = pred_lsu();
      tick();
      if (gi) IFUReq = ($urandom_range(0, 3) == 0);
      if (gl) LSUReq = ($urandom_range(0, 3) == 0);
    end
    reset = 0;
  endtask

  initial begin
`ifdef PERIPH_ARB_OVERLAP_CHECK_EN
    overlap_en = 1;
`else
    overlap_en = 0;
`endif
    reset = 1; IFUReq = 0; LSUReq = 0; LSUWrite = 0; RspReady = 0;
    IFUAdr = '0; LSUAdr = '0; IFUSize = 0; LSUSize = 0; DecSel = 8'h00;
    m_phase = 0; m_adr = '0; m_size = 0; m_write = 0; m_owner = 0;
    m_rsp_owner = 0; m_rsp_fault = 0; m_rsp_sel = '0;
    test_reset();
    test_single_lsu();
    test_fairness();
    test_fault_stall();
    test_overlap();
    test_reset_mid();
    test_ifu_nowrite();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/periph_decode_arb.md
# periph_decode_arb

Shares one peripheral address-decode path (a bank of range comparators producing a per-region select vector) between the instruction-fetch and load/store requesters in the MMU. It arbitrates, latches the winning request, drives the shared decoder for one cycle, captures and checks the select vector, and returns a held response under a valid/ready handshake. It sits between the IFU/LSU bus front-ends and the external decoder bank.

## Interface
- PA_BITS, default 56: physical address width.
- NREGIONS, default 8: number of decoder regions / width of the select vector.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- IFUReq  in  1  instruction-side request; held until IFUGnt.
- IFUAdr  in  PA_BITS  instruction-side physical address.
- IFUSize  in  2  access size: 0=8, 1=16, 2=32, 3=64-bit.
- IFUGnt  out  1  one-cycle pulse; the IFU request is accepted this cycle.
- LSUReq  in  1  load/store request; held until LSUGnt.
- LSUAdr  in  PA_BITS  load/store physical address.
- LSUSize  in  2  load/store access size.
- LSUWrite  in  1  1 = store, 0 = load.
- LSUGnt  out  1  one-cycle pulse; the LSU request is accepted this cycle.
- DecAdr  out  PA_BITS  address driven to the shared decoder.
- DecSize  out  2  size driven to the shared decoder.
- DecWrite  out  1  write flag driven to the decoder; always 0 for IFU.
- DecSel  in  NREGIONS  combinational select vector returned by the decoder.
- RspValid  out  1  response is valid.
- RspOwner  out  1  0 = IFU, 1 = LSU.
- RspSel  out  NREGIONS  captured select vector.
- RspFault  out  1  access fault: no region matched, or overlap (see Configuration).
- RspReady  in  1  consumer accepts the response.

## Operation
- States: IDLE, DECODE, RESP. Reset enters IDLE.
- IDLE: if either Req is high, grant exactly one. Pulse the matching Gnt, latch Adr/Size/Write/owner, and go to DECODE. With no request, stay in IDLE. Gnt is never asserted outside IDLE.
- Arbitration: LSU has priority. Exception: IFU wins when both request and the LSU has won the last 2 consecutive contested grants.
  - StarveCnt (2-bit, saturating at 2) increments when LSU wins while IFU is requesting.
  - StarveCnt clears on any IFU grant.
  - It is unchanged on an uncontested LSU grant.
- DECODE: DecAdr/DecSize/DecWrite present the latched values. At the end of the cycle, sample DecSel into RspSel and compute RspFault. Go to RESP.
- RESP: RspValid=1. RspOwner, RspSel and RspFault are held stable until RspReady. When RspValid&RspReady, go to IDLE.
- Fault rule: RspFault=1 if DecSel==0. On a fault, RspSel is forced to 0.
- Dec* outputs hold the last latched values in all states.
- A Req dropped before its Gnt is legal and has no effect.

## Timing
- Grant in cycle N. DecAdr is valid in N+1. RspValid rises in N+2.
- Minimum of 3 cycles per transaction; no grant in the same cycle as a RspReady handshake.
- Reset values: IFUGnt=0, LSUGnt=0, RspValid=0, RspOwner=0, RspSel=0, RspFault=0, DecAdr=0, DecSize=0, DecWrite=0, StarveCnt=0.
- Reset asserted mid-transaction (DECODE or RESP) aborts it. The next cycle is IDLE with all reset values and no response is produced. Requesters must re-present a Req that was not granted.
- RspReady high while not in RESP is ignored.

## Configuration
- PERIPH_ARB_OVERLAP_CHECK_EN defined: a DecSel with more than one bit set is also a fault (RspFault=1, RspSel=0). This is a popcount>1 check.
- Undefined: a multi-hot DecSel passes through to RspSel with RspFault=0. Only DecSel==0 faults.

## Test plan
- Single LSU request, LSUAdr=0x0200_0000, DecSel=8'h04, RspReady=1 -> LSUGnt at N, DecAdr=0x0200_0000 at N+1, RspValid/RspOwner=1/RspSel=8'h04/RspFault=0 at N+2, IDLE at N+3.
- IFU and LSU both request continuously, RspReady=1 -> grant order LSU, LSU, IFU, LSU, LSU, IFU; never more than 2 consecutive LSU grants.
- DecSel=8'h00 -> RspFault=1, RspSel=0. RspReady held low for 5 cycles -> RspValid and all Rsp fields stable for all 5 cycles, and no Gnt issued.
- DecSel=8'h05 -> with PERIPH_ARB_OVERLAP_CHECK_EN, RspFault=1 and RspSel=0. Without it, RspFault=0 and RspSel=8'h05.
- Reset pulsed in DECODE -> next cycle RspValid=0, all outputs at reset values; a pending IFUReq is granted on the first IDLE cycle after reset deasserts.
- IFU store-like stimulus: IFU granted with LSUWrite=1 asserted on the LSU side but LSUReq=0 -> DecWrite=0 during DECODE.
